// File: rtl/layer_mac_array.sv
// layer_mac_array: run-time configurable fully-connected layer engine.
//
// Computes y[i] = act(sat(sum_j W[i][j]*x[j] + b[i])) for i = 0..M-1 using
// P parallel MAC lanes. W and b arrive over a config stream, x over an input
// stream, and y leaves over an output stream. All three use valid/ready.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset (release synchronised)
//   cfg_valid  in   config word valid
//   cfg_ready  out  config word accepted when cfg_valid && cfg_ready
//   cfg_data   in   W row-major (M*N words), then b (M words)
//   cfg_reload in   return to config load; honoured only before the first x word
//   s_valid    in   x word valid
//   s_ready    out  x word accepted when s_valid && s_ready
//   data_in    in   x[j], j ascending
//   m_valid    out  y word valid
//   m_ready    in   y word accepted when m_valid && m_ready
//   data_out   out  y[i], i ascending
//   ovf        out  current y saturated or wrapped
module layer_mac_array #(
   parameter int M       = 8,
   parameter int N       = 8,
   parameter int P       = 2,
   parameter int T       = 12,
   parameter int RELU_EN = 1,
   parameter int SAT_EN  = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic [T-1:0] cfg_data,
   input  logic         cfg_reload,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [T-1:0] data_in,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [T-1:0] data_out,
   output logic         ovf
);

   localparam int KP = M / P;
   localparam int MI = (M > 1) ? $clog2(M) : 1;
   localparam int NI = (N > 1) ? $clog2(N) : 1;
   localparam int PI = (P > 1) ? $clog2(P) : 1;
   localparam int KI = (KP > 1) ? $clog2(KP) : 1;
   localparam int CI = $clog2(N + 2);
   localparam int PW = 2 * T;
   localparam int AW = 2 * T + $clog2(N) + 1;

   localparam logic [MI-1:0] ROW_LAST  = MI'(M - 1);
   localparam logic [NI-1:0] COL_LAST  = NI'(N - 1);
   localparam logic [PI-1:0] LANE_LAST = PI'(P - 1);
   localparam logic [KI-1:0] PASS_LAST = KI'(KP - 1);
   localparam logic [CI-1:0] CYC_NCOL  = CI'(N);
   localparam logic [CI-1:0] CYC_FIRST = CI'(2);
   localparam logic [CI-1:0] CYC_FIN   = CI'(N + 1);
   localparam logic signed [AW-1:0] SAT_MAX  = AW'((2 ** (T - 1)) - 1);
   localparam logic signed [AW-1:0] SAT_MIN  = AW'(-(2 ** (T - 1)));
   localparam logic signed [AW-1:0] ACC_ZERO = AW'(0);

   if ((M % P) != 0) begin : g_bad_lanes
      $error("layer_mac_array: M must be a multiple of P");
   end
   if ((P < 1) || (P > M)) begin : g_bad_p
      $error("layer_mac_array: P must lie in 1..M");
   end

   typedef enum logic [1:0] {
      LOAD_CFG = 2'd0,
      GET_X    = 2'd1,
      COMPUTE  = 2'd2,
      DRAIN    = 2'd3
   } state_e;

   // ---------------------------------------------------------------------
   // Declarations
   // ---------------------------------------------------------------------
   logic [1:0]  rst_sync_q;
   logic        rst_n_s;

   state_e      state_q;
   logic [MI-1:0] cfg_row_q;
   logic [NI-1:0] cfg_col_q;
   logic        cfg_bias_q;
   logic [NI-1:0] x_cnt_q;
   logic [KI-1:0] pass_q;
   logic [CI-1:0] cyc_q;

   logic signed [T-1:0] w_mem [M][N];
   logic signed [T-1:0] b_mem [M];
   logic signed [T-1:0] x_mem [N];

   logic signed [T-1:0]  x_rd_q;
   logic signed [T-1:0]  w_rd_q [P];
   logic signed [PW-1:0] prod_q [P];
   logic signed [AW-1:0] acc_q  [P];

   logic [T-1:0] buf_q     [P];
   logic         buf_ovf_q [P];
   logic [PI-1:0] out_idx_q;
   logic         m_valid_q;
   logic [T-1:0] data_out_q;
   logic         ovf_q;

   logic [MI-1:0] row_s [P];
   logic [NI-1:0] col_s;
   logic signed [AW-1:0] sum_s     [P];
   logic signed [AW-1:0] fin_raw_s [P];
   logic [T-1:0] fin_d     [P];
   logic         fin_ovf_d [P];

   logic cfg_fire_s;
   logic reload_s;
   logic s_fire_s;
   logic m_fire_s;
   logic out_last_s;
   logic run_s;
   logic fin_s;

   // Reset synchroniser: assertion reaches all state at once, release is clocked.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end
   assign rst_n_s = rst_sync_q[1];

   // ---------------------------------------------------------------------
   // Handshakes and pass sequencing
   // ---------------------------------------------------------------------
   assign cfg_ready  = (state_q == LOAD_CFG);
   // A reload request at the start of a vector takes priority over data.
   assign reload_s   = (state_q == GET_X) && cfg_reload && (x_cnt_q == '0);
   assign s_ready    = (state_q == GET_X) && !(cfg_reload && (x_cnt_q == '0));
   assign cfg_fire_s = cfg_valid && cfg_ready;
   assign s_fire_s   = s_valid && s_ready;
   assign m_fire_s   = m_valid_q && m_ready;
   assign out_last_s = m_fire_s && (out_idx_q == LANE_LAST);
   // A pass may only begin once the previous pass's results have all left.
   assign run_s      = (state_q == COMPUTE) && !((cyc_q == '0) && m_valid_q);
   assign fin_s      = run_s && (cyc_q == CYC_FIN);

   // Main FSM: config load, x gather, compute passes, final drain.
   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         state_q    <= LOAD_CFG;
         cfg_row_q  <= '0;
         cfg_col_q  <= '0;
         cfg_bias_q <= 1'b0;
         x_cnt_q    <= '0;
         pass_q     <= '0;
         cyc_q      <= '0;
      end else begin
         case (state_q)
            LOAD_CFG: begin
               if (cfg_fire_s) begin
                  if (!cfg_bias_q) begin
                     if (cfg_col_q == COL_LAST) begin
                        cfg_col_q <= '0;
                        if (cfg_row_q == ROW_LAST) begin
                           cfg_row_q  <= '0;
                           cfg_bias_q <= 1'b1;
                        end else begin
                           cfg_row_q <= cfg_row_q + MI'(1);
                        end
                     end else begin
                        cfg_col_q <= cfg_col_q + NI'(1);
                     end
                  end else begin
                     if (cfg_row_q == ROW_LAST) begin
                        cfg_row_q  <= '0;
                        cfg_bias_q <= 1'b0;
                        state_q    <= GET_X;
                     end else begin
                        cfg_row_q <= cfg_row_q + MI'(1);
                     end
                  end
               end
            end
            GET_X: begin
               if (reload_s) begin
                  state_q <= LOAD_CFG;
               end else if (s_fire_s) begin
                  if (x_cnt_q == COL_LAST) begin
                     x_cnt_q <= '0;
                     pass_q  <= '0;
                     cyc_q   <= '0;
                     state_q <= COMPUTE;
                  end else begin
                     x_cnt_q <= x_cnt_q + NI'(1);
                  end
               end
            end
            COMPUTE: begin
               if (run_s) begin
                  if (cyc_q == CYC_FIN) begin
                     cyc_q <= '0;
                     if (pass_q == PASS_LAST) begin
                        pass_q  <= '0;
                        state_q <= DRAIN;
                     end else begin
                        pass_q <= pass_q + KI'(1);
                     end
                  end else begin
                     cyc_q <= cyc_q + CI'(1);
                  end
               end
            end
            DRAIN: begin
               if (out_last_s) begin
                  state_q <= GET_X;
               end
            end
            default: begin
               state_q <= LOAD_CFG;
            end
         endcase
      end
   end

   // Coefficient and input storage; written on accepted words, never reset.
   always_ff @(posedge clk) begin
      if (cfg_fire_s) begin
         if (cfg_bias_q) begin
            b_mem[cfg_row_q] <= cfg_data;
         end else begin
            w_mem[cfg_row_q][cfg_col_q] <= cfg_data;
         end
      end
      if (s_fire_s) begin
         x_mem[x_cnt_q] <= data_in;
      end
   end

   // ---------------------------------------------------------------------
   // Datapath: cycle c reads column c, product lands at c+2, finalise at N+1
   // ---------------------------------------------------------------------

   // Lane row/column selection and finalisation (bias, saturate/wrap, ReLU).
   always_comb begin
      if (cyc_q < CYC_NCOL) begin
         col_s = NI'(cyc_q);
      end else begin
         col_s = '0;
      end
      for (int l = 0; l < P; l++) begin
         row_s[l] = MI'(int'(pass_q) * P + l);
         // The first product of a pass starts a fresh sum.
         if (cyc_q == CYC_FIRST) begin
            sum_s[l] = ACC_ZERO + AW'(prod_q[l]);
         end else begin
            sum_s[l] = acc_q[l] + AW'(prod_q[l]);
         end
         fin_raw_s[l] = sum_s[l] + AW'(b_mem[row_s[l]]);
         // Out of T-bit range means clipped when saturating, and upper bits
         // that are not a sign extension when wrapping: the same condition.
         fin_ovf_d[l] = (fin_raw_s[l] > SAT_MAX) || (fin_raw_s[l] < SAT_MIN);
         if ((SAT_EN != 0) && (fin_raw_s[l] > SAT_MAX)) begin
            fin_d[l] = SAT_MAX[T-1:0];
         end else if ((SAT_EN != 0) && (fin_raw_s[l] < SAT_MIN)) begin
            fin_d[l] = SAT_MIN[T-1:0];
         end else begin
            fin_d[l] = fin_raw_s[l][T-1:0];
         end
         if ((RELU_EN != 0) && fin_d[l][T-1]) begin
            fin_d[l] = '0;
         end else begin
            fin_d[l] = fin_d[l];
         end
      end
   end

   // MAC pipeline: registered operand read, registered product, accumulate.
   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         x_rd_q <= '0;
         for (int l = 0; l < P; l++) begin
            w_rd_q[l] <= '0;
            prod_q[l] <= '0;
            acc_q[l]  <= '0;
         end
      end else if (run_s) begin
         x_rd_q <= x_mem[col_s];
         for (int l = 0; l < P; l++) begin
            w_rd_q[l] <= w_mem[row_s[l]][col_s];
            prod_q[l] <= PW'(w_rd_q[l]) * PW'(x_rd_q);
            if (cyc_q >= CYC_FIRST) begin
               acc_q[l] <= sum_s[l];
            end
         end
      end
   end

   // Output buffer and registered output port, held while stalled.
   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         m_valid_q  <= 1'b0;
         data_out_q <= '0;
         ovf_q      <= 1'b0;
         out_idx_q  <= '0;
         for (int l = 0; l < P; l++) begin
            buf_q[l]     <= '0;
            buf_ovf_q[l] <= 1'b0;
         end
      end else if (fin_s) begin
         // Lane 0 goes straight to the port so the first result is not delayed.
         m_valid_q  <= 1'b1;
         data_out_q <= fin_d[0];
         ovf_q      <= fin_ovf_d[0];
         out_idx_q  <= '0;
         for (int l = 0; l < P; l++) begin
            buf_q[l]     <= fin_d[l];
            buf_ovf_q[l] <= fin_ovf_d[l];
         end
      end else if (m_fire_s) begin
         if (out_idx_q == LANE_LAST) begin
            m_valid_q <= 1'b0;
            out_idx_q <= '0;
         end else begin
            out_idx_q  <= out_idx_q + PI'(1);
            data_out_q <= buf_q[out_idx_q + PI'(1)];
            ovf_q      <= buf_ovf_q[out_idx_q + PI'(1)];
         end
      end
   end

   assign m_valid  = m_valid_q;
   assign data_out = data_out_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_layer_mac_array.sv
// Directed bench for layer_mac_array. Two instances share all stimulus:
// dut_a uses ReLU + saturation, dut_b uses signed pass-through + wrap.
module tb_layer_mac_array;

   localparam int M   = 8;
   localparam int N   = 8;
   localparam int P   = 2;
   localparam int T   = 12;
   localparam int LIM = 400;

   logic         clk = 1'b0;
   logic         reset;
   logic         cfg_valid, cfg_reload, s_valid, m_ready;
   logic [T-1:0] cfg_data, data_in;
   logic         cfg_ready_a, s_ready_a, m_valid_a, ovf_a;
   logic [T-1:0] data_out_a;
   logic         cfg_ready_b, s_ready_b, m_valid_b, ovf_b;
   logic [T-1:0] data_out_b;

   int checks_cnt = 0;
   int errors_cnt = 0;

   int w_arr [M*N];
   int b_arr [M];
   int x_arr [N];
   int exp_a [M];
   int exp_b [M];
   int eovf_a, eovf_b;

   always #5 clk = ~clk;

   layer_mac_array #(.M(M), .N(N), .P(P), .T(T), .RELU_EN(1), .SAT_EN(1)) dut_a (
      .clk(clk), .reset(reset),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_a), .cfg_data(cfg_data), .cfg_reload(cfg_reload),
      .s_valid(s_valid), .s_ready(s_ready_a), .data_in(data_in),
      .m_valid(m_valid_a), .m_ready(m_ready), .data_out(data_out_a), .ovf(ovf_a)
   );

   layer_mac_array #(.M(M), .N(N), .P(P), .T(T), .RELU_EN(0), .SAT_EN(0)) dut_b (
      .clk(clk), .reset(reset),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_b), .cfg_data(cfg_data), .cfg_reload(cfg_reload),
      .s_valid(s_valid), .s_ready(s_ready_b), .data_in(data_in),
      .m_valid(m_valid_b), .m_ready(m_ready), .data_out(data_out_b), .ovf(ovf_b)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_diag(input int d, input int bias);
      for (int i = 0; i < M; i++) begin
         for (int j = 0; j < N; j++) w_arr[i*N+j] = (i == j) ? d : 0;
         b_arr[i] = bias;
      end
   endtask

   task automatic load_cfg();
      int n;
      for (int i = 0; i < M*N+M; i++) begin
         cfg_valid = 1'b1;
         cfg_data  = (i < M*N) ? T'(w_arr[i]) : T'(b_arr[i-M*N]);
         n = 0;
         while (!cfg_ready_a && n < LIM) begin @(posedge clk); #1; n++; end
         if (n >= LIM) check_eq("tmo_cfg", n, 0);
         @(posedge clk); #1;
      end
      cfg_valid = 1'b0;
      check_eq("cfg_ready_after_load", int'(cfg_ready_a), 0);
      check_eq("s_ready_after_load", int'(s_ready_a), 1);
   endtask

   task automatic do_reload(input string tag);
      cfg_reload = 1'b1;
      s_valid    = 1'b1;
      data_in    = T'(777);
      #1;
      check_eq({tag, "_s_ready_blocked"}, int'(s_ready_a), 0);
      @(posedge clk); #1;
      cfg_reload = 1'b0;
      s_valid    = 1'b0;
      check_eq({tag, "_cfg_ready"}, int'(cfg_ready_a), 1);
   endtask

   task automatic send_x(input int reload_at);
      int n;
      for (int j = 0; j < N; j++) begin
         s_valid    = 1'b1;
         data_in    = T'(x_arr[j]);
         cfg_reload = (reload_at >= 0) && (j >= reload_at);
         n = 0;
         while (!s_ready_a && n < LIM) begin @(posedge clk); #1; n++; end
         if (n >= LIM) check_eq("tmo_x", n, 0);
         @(posedge clk); #1;
      end
      s_valid    = 1'b0;
      cfg_reload = 1'b0;
   endtask

   // Collect M outputs from both instances; bp randomises m_ready.
   task automatic collect(input string tag, input bit bp, input bit chk_lat);
      int got, n, first, bad_hold, bad_sr;
      bit stall;
      logic [T-1:0] hold;
      got = 0; n = 0; first = -1; bad_hold = 0; bad_sr = 0; stall = 1'b0; hold = '0;
      while (got < M && n < LIM) begin
         m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stall && !(m_valid_a && data_out_a == hold)) bad_hold++;
         if (s_ready_a) bad_sr++;
         if (m_valid_a && first < 0) first = n;
         if (m_valid_a && m_ready) begin
            check_eq($sformatf("%s_a_y%0d", tag, got), int'($signed(data_out_a)), exp_a[got]);
            check_eq($sformatf("%s_b_y%0d", tag, got), int'($signed(data_out_b)), exp_b[got]);
            check_eq($sformatf("%s_a_ovf%0d", tag, got), int'(ovf_a), eovf_a);
            check_eq($sformatf("%s_b_ovf%0d", tag, got), int'(ovf_b), eovf_b);
            got++;
            stall = 1'b0;
         end else if (m_valid_a) begin
            stall = 1'b1;
            hold  = data_out_a;
         end else begin
            stall = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      m_ready = 1'b1;
      if (n >= LIM) check_eq({tag, "_tmo_out"}, got, M);
      if (chk_lat) check_eq({tag, "_latency"}, first + 1, N + 3);
      check_eq({tag, "_hold_stable"}, bad_hold, 0);
      check_eq({tag, "_s_ready_low"}, bad_sr, 0);
      check_eq({tag, "_s_ready_back"}, int'(s_ready_a), 1);
   endtask

   initial begin
      int n, got;
      reset = 1'b0; cfg_valid = 1'b0; cfg_reload = 1'b0; s_valid = 1'b0;
      m_ready = 1'b1; cfg_data = '0; data_in = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_cfg_ready", int'(cfg_ready_a), 1);
      check_eq("rst_s_ready", int'(s_ready_a), 0);
      check_eq("rst_m_valid", int'(m_valid_a), 0);
      check_eq("rst_data_out", int'(data_out_a), 0);
      check_eq("rst_ovf", int'(ovf_a), 0);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Identity: y = x, latency N+3.
      set_diag(1, 0);
      load_cfg();
      x_arr = '{1, 2, 3, 4, 5, 6, 7, 8};
      exp_a = '{1, 2, 3, 4, 5, 6, 7, 8};
      exp_b = '{1, 2, 3, 4, 5, 6, 7, 8};
      eovf_a = 0; eovf_b = 0;
      send_x(-1);
      collect("ident", 1'b0, 1'b1);

      // Reload with data offered: reload wins; then W = 2I, late reload ignored.
      do_reload("reload1");
      set_diag(2, 0);
      load_cfg();
      exp_a = '{2, 4, 6, 8, 10, 12, 14, 16};
      exp_b = '{2, 4, 6, 8, 10, 12, 14, 16};
      send_x(3);
      check_eq("late_reload_ignored", int'(cfg_ready_a), 0);
      collect("twice", 1'b0, 1'b1);

      // Bias -5 with and without ReLU.
      do_reload("reload2");
      set_diag(1, -5);
      load_cfg();
      x_arr = '{3, 10, -2, 5, 0, 7, 6, 4};
      exp_a = '{0, 5, 0, 0, 0, 2, 1, 0};
      exp_b = '{-2, 5, -7, 0, -5, 2, 1, -1};
      send_x(-1);
      collect("relu", 1'b0, 1'b0);

      // 8*100*100 = 80000: saturates to 2047, wraps to -1920.
      do_reload("reload3");
      for (int i = 0; i < M*N; i++) w_arr[i] = 100;
      for (int i = 0; i < M; i++) b_arr[i] = 0;
      load_cfg();
      x_arr = '{100, 100, 100, 100, 100, 100, 100, 100};
      exp_a = '{2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047};
      exp_b = '{-1920, -1920, -1920, -1920, -1920, -1920, -1920, -1920};
      eovf_a = 1; eovf_b = 1;
      send_x(-1);
      collect("sat", 1'b0, 1'b0);

      // Backpressure over three vectors.
      do_reload("reload4");
      set_diag(1, 0);
      load_cfg();
      eovf_a = 0; eovf_b = 0;
      x_arr = '{10, 11, 12, 13, 14, 15, 16, 17};
      exp_a = '{10, 11, 12, 13, 14, 15, 16, 17};
      exp_b = '{10, 11, 12, 13, 14, 15, 16, 17};
      send_x(-1);
      collect("bp1", 1'b1, 1'b0);
      x_arr = '{100, 200, 300, 400, 500, 600, 700, 800};
      exp_a = '{100, 200, 300, 400, 500, 600, 700, 800};
      exp_b = '{100, 200, 300, 400, 500, 600, 700, 800};
      send_x(-1);
      collect("bp2", 1'b1, 1'b0);
      x_arr = '{-1, 2, -3, 4, -5, 6, -7, 8};
      exp_a = '{0, 2, 0, 4, 0, 6, 0, 8};
      exp_b = '{-1, 2, -3, 4, -5, 6, -7, 8};
      send_x(-1);
      collect("bp3", 1'b1, 1'b0);

      // Reset while pass 1 results are presented.
      x_arr = '{1, 2, 3, 4, 5, 6, 7, 8};
      send_x(-1);
      got = 0; n = 0;
      while (got < P && n < LIM) begin
         if (m_valid_a) got++;
         @(posedge clk); #1; n++;
      end
      m_ready = 1'b0;
      n = 0;
      while (!m_valid_a && n < LIM) begin @(posedge clk); #1; n++; end
      check_eq("mid_m_valid_before", int'(m_valid_a), 1);
      #2;
      reset = 1'b0;
      #1;
      check_eq("mid_rst_m_valid_a", int'(m_valid_a), 0);
      check_eq("mid_rst_m_valid_b", int'(m_valid_b), 0);
      check_eq("mid_rst_cfg_ready", int'(cfg_ready_a), 1);
      check_eq("mid_rst_data_out", int'(data_out_a), 0);
      @(posedge clk); #1;
      reset = 1'b1;
      m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("post_rst_cfg_ready", int'(cfg_ready_a), 1);
      check_eq("post_rst_s_ready", int'(s_ready_a), 0);
      set_diag(1, 0);
      load_cfg();
      exp_a = '{1, 2, 3, 4, 5, 6, 7, 8};
      exp_b = '{1, 2, 3, 4, 5, 6, 7, 8};
      send_x(-1);
      collect("after_rst", 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule

// File: doc/layer_mac_array.md
Name: layer_mac_array

Overview:
- Parametrised fully-connected layer engine: y[i] = act(sat(sum_j W[i][j]*x[j] + b[i])) for i = 0..M-1.
- W and b are loaded at run time over a config stream, so one netlist serves any trained layer. No per-layer ROMs are generated.
- P MAC lanes compute P output rows in parallel.
- Sits between layer stages; valid/ready on both input and output, so layers chain directly.

Parameters:
- M, 8, number of outputs (rows of W); M % P == 0 is required, elaboration error otherwise.
- N, 8, number of inputs (columns of W).
- P, 2, parallel MAC lanes, 1..M.
- T, 12, signed data width of x, W, b and y.
- RELU_EN, 1, 1 clamps negative results to 0; 0 passes signed results.
- SAT_EN, 1, 1 saturates the result to T-bit signed range; 0 keeps the low T bits (wrap).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset; assertion is immediate, deassertion is synchronised internally to clk.
- cfg_valid  in  1  config word valid.
- cfg_ready  out  1  config word accepted when cfg_valid && cfg_ready.
- cfg_data  in  T  signed config word: M*N weights row-major (W[0][0..N-1], W[1][..], ...), then M biases.
- cfg_reload  in  1  request reload of config; sampled only in GET_X with zero x words accepted.
- s_valid  in  1  input x word valid.
- s_ready  out  1  x word accepted when s_valid && s_ready.
- data_in  in  T  signed x[j], j ascending.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts when m_valid && m_ready.
- data_out  out  T  y[i], i ascending 0..M-1.
- ovf  out  1  qualifies data_out: the current y saturated (SAT_EN=1) or wrapped (SAT_EN=0).

Behaviour:
- Reset state:
  - state = LOAD_CFG; all counters 0.
  - cfg_ready = 1, s_ready = 0, m_valid = 0, data_out = 0, ovf = 0.
  - W/b/x storage is not reset.
- LOAD_CFG:
  - Each accepted word is written at cfg_cnt, which increments.
  - After word M*N+M-1 is accepted, the next cycle is GET_X and cfg_ready drops.
  - There is no partial-config escape; reset mid-load restarts the load from word 0.
- GET_X:
  - s_ready = 1; each accepted word is stored to x[x_cnt], which increments.
  - After word N-1 is accepted, go to COMPUTE with x_cnt = 0.
  - cfg_reload=1 while x_cnt==0 goes to LOAD_CFG. cfg_reload with x_cnt>0 is ignored.
  - If cfg_reload and s_valid are both high at x_cnt==0, reload wins and s_ready is 0 that cycle.
- COMPUTE, pass k = 0..M/P-1:
  - Lane l computes row k*P+l.
  - Cycle c = 0..N-1 reads W[row][c] and x[c] (registered read).
  - The product is registered, then accumulated.
  - Accumulator width = 2T + clog2(N) + 1, so it never overflows internally.
  - Bias is added sign-extended at finalise.
  - Finalise:
    - Saturate to [-(2^(T-1)), 2^(T-1)-1] (SAT_EN=1, ovf=1 if clipped), or truncate (SAT_EN=0, ovf=1 if the discarded upper bits are not a sign extension).
    - Then ReLU if RELU_EN.
    - ReLU does not clear ovf.
  - Finalised lane results go to a P-entry output buffer.
  - The next pass starts only when the output buffer is empty (backpressure stalls compute, no loss).
- Output:
  - The buffer is emitted lane 0..P-1, giving global order y[0]..y[M-1].
  - m_valid, data_out and ovf are registered and held stable while m_valid && !m_ready.
  - Latency: first m_valid rises N+3 cycles after the cycle the last x word is accepted, given m_ready=1 throughout.
  - With m_ready=1, a pass takes N+3 cycles and its P outputs drain in P cycles. The next pass starts the cycle after the last buffer entry is accepted.
- Return:
  - After y[M-1] is accepted, go to GET_X the next cycle.
  - W/b are retained; x is overwritten by the next vector.
- s_ready = 0 and cfg_ready = 0 outside their states.
- Reset asserted mid-compute or mid-output drops m_valid immediately (async), discards the partial vector and returns to LOAD_CFG.

Test Plan:
- Identity: M=N=8, P=2, T=12. Load W=I, b=0; x = 1..8 -> y = 1..8 in order, ovf=0; first m_valid exactly N+3=11 cycles after the last x is accepted.
- ReLU and bias: W=I, b[i] = -5; x = {3,10,-2,5,0,7,6,4} -> y = {0,5,0,0,0,2,1,0}; with RELU_EN=0 -> {-2,5,-7,0,-5,2,1,-1}.
- Saturation: all W = 100, b = 0, x all 100, T=12 -> every y=2047, ovf=1. With SAT_EN=0 -> y = 80000 mod 4096 = 2176, reinterpreted signed as -1920, ovf=1.
- Backpressure: m_ready toggling 1,0,0,1 randomly over 3 vectors -> no dropped or duplicated y; data_out stable while stalled; s_ready stays 0 until y[7] is accepted.
- Reload: after a vector completes, pulse cfg_reload with s_valid=1 at x_cnt=0 -> LOAD_CFG entered, no x word accepted. Load W = 2*I -> next x = 1..8 gives y = 2..16. cfg_reload at x_cnt=3 is ignored.
- Reset mid-operation: assert reset during pass 2 with m_valid=1 -> m_valid=0 the same cycle (async); after release cfg_ready=1, and a full reload plus vector gives correct results.
